// File: rtl/logic_pulse_logger_if.sv
// logic_pulse_logger_if: valid/ready record stream from the pulse logger to its consumer
interface logic_pulse_logger_if #(parameter int CNT_W = 8);
    logic [CNT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/logic_pulse_logger.sv
// logic_pulse_logger: measures high-pulse widths of e_in and queues them for a valid/ready consumer
module logic_pulse_logger #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4,
    parameter int EVT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    e_in,
    input  logic                    clr_ovf,
    logic_pulse_logger_if.master    rec,
    output logic [EVT_W-1:0]        evt_count,
    output logic                    ovf
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, MEAS} state_t;
    state_t           state;
    logic             e_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ;
    logic             push, pop, full, accept, drop, valid;
    // A completed pulse is accepted when there is room or the head leaves on the same edge
    always_comb begin
        valid         = occ != '0;
        push          = state == MEAS && en && !e_q;
        pop           = valid && rec.out_ready;
        full          = occ == (AW+1)'(DEPTH);
        accept        = push && (!full || pop);
        drop          = push && full && !pop;
        rec.out_valid = valid;
        rec.out_data  = valid ? mem[rd_ptr] : '0;
    end
    // Input register; the FSM only ever looks at the registered copy
    always_ff @(posedge clk)
        e_q <= rst_n ? e_in : 1'b0;
    // Width measurement: start on a high sample, count with saturation, finish on a low sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            state <= en && e_q ? MEAS : IDLE;
            cnt   <= en && e_q ? CNT_W'(1) : cnt;
        end else begin
            state <= en && e_q ? MEAS : IDLE;
            cnt   <= en && e_q && !(&cnt) ? cnt + CNT_W'(1) : cnt;
        end
    end
    // Record storage; unread slots need no reset since out_data is masked when empty
    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= cnt;
    // Queue bookkeeping, event count and sticky overflow (a drop beats a clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            evt_count <= '0;
            ovf       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(accept);
            rd_ptr    <= rd_ptr + AW'(pop);
            occ       <= occ + (AW+1)'(accept) - (AW+1)'(pop);
            evt_count <= evt_count + EVT_W'(accept);
            ovf       <= drop || (ovf && !clr_ovf);
        end
    end
endmodule
